sram_arbiter: RTL and testbench

//  Shares the single external SRAM port (address/write-data/we_n of the SRAM controller) among the

---
 rtl/sram_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin burst arbiter sharing one SRAM controller port among NUM_REQ masters; req->gnt 1 cycle,
// read data returned READ_LATENCY cycles after issue. Masters wait on gnt_o low; one dead cycle between owners.
module sram_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int READ_LATENCY = 3,
  parameter int MAX_HOLD     = 0
) (
  input  logic                  Clock_50,
  input  logic                  Resetn,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*18-1:0] addr_i,
  input  logic [NUM_REQ*16-1:0] wdata_i,
  input  logic [NUM_REQ-1:0]    we_n_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [15:0]           rdata_o,
  output logic [NUM_REQ-1:0]    rvalid_o,
  output logic [1:0]            owner_o,
  output logic                  busy_o,
  output logic [17:0]           SRAM_address_o,
  output logic [15:0]           SRAM_write_data_o,
  output logic                  SRAM_we_n_o,
  input  logic [15:0]           SRAM_read_data_i
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  // The rdata/rvalid output register is the last latency stage, so the tag pipe is one shorter.
  localparam int PD = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         rr_q, rr_d;
  logic [HW-1:0]      hold_q, hold_d, hold_nxt;
  logic [17:0]        addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [PD-1:0]      tag_vld_q, tag_vld_d;
  logic [1:0]         tag_idx_q [PD];
  logic [1:0]         tag_idx_d [PD];
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [15:0]        rdata_q, rdata_d;

  logic        issue, cur_we_n, others, force_rel, pick_vld;
  logic [17:0] cur_addr;
  logic [15:0] cur_wdata;
  logic [1:0]  pick, cand;

  always_comb begin
    pick_vld = 1'b0;
    pick     = rr_q;
    cand     = rr_q;
    // Walk backwards so the requester closest to the RR pointer wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = 2'((int'(rr_q) + i) % NUM_REQ);
      if (req_i[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    issue     = (state_q == S_GRANT) && gnt_q[owner_q] && req_i[owner_q];
    cur_addr  = addr_i[int'(owner_q)*18 +: 18];
    cur_wdata = wdata_i[int'(owner_q)*16 +: 16];
    cur_we_n  = we_n_i[owner_q];
    others    = |(req_i & ~gnt_q);
    hold_nxt  = (issue && (hold_q != HW'(MAX_HOLD))) ? hold_q + HW'(1) : hold_q;
    force_rel = (MAX_HOLD != 0) && (hold_nxt == HW'(MAX_HOLD)) && others;

    SRAM_address_o    = issue ? cur_addr : addr_q;
    SRAM_write_data_o = issue ? cur_wdata : wdata_q;
    SRAM_we_n_o       = issue ? cur_we_n : 1'b1;
    addr_d            = SRAM_address_o;
    wdata_d           = SRAM_write_data_o;

    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    case (state_q)
      S_GRANT: begin
        hold_d = hold_nxt;
        if (!req_i[owner_q] || force_rel) begin
          gnt_d   = '0;
          rr_d    = (owner_q == 2'(NUM_REQ - 1)) ? 2'd0 : owner_q + 2'd1;
          state_d = S_RELEASE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
        if (pick_vld) begin
          gnt_d   = NUM_REQ'(1) << pick;
          owner_d = pick;
          hold_d  = '0;
          state_d = S_GRANT;
        end
      end
    endcase

    tag_vld_d    = '0;
    tag_idx_d    = tag_idx_q;
    tag_vld_d[0] = issue & cur_we_n;
    tag_idx_d[0] = owner_q;
    for (int s = 1; s < PD; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
    rvalid_d = tag_vld_q[PD-1] ? (NUM_REQ'(1) << tag_idx_q[PD-1]) : '0;
    rdata_d  = tag_vld_q[PD-1] ? SRAM_read_data_i : rdata_q;
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
      hold_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tag_vld_q <= '0;
      for (int s = 0; s < PD; s++) tag_idx_q[s] <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign busy_o   = |gnt_q;
  assign owner_o  = owner_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: vector table for basic bursts/writes, hand sequences for hold and reset.
module tb_sram_arbiter;
  logic        Clock_50 = 1'b0;
  logic        Resetn   = 1'b0;
  logic [2:0]  req_i    = '0;
  logic [53:0] addr_i   = '0;
  logic [47:0] wdata_i  = '0;
  logic [2:0]  we_n_i   = 3'b111;
  logic [2:0]  gnt_o, rvalid_o;
  logic [15:0] rdata_o, SRAM_write_data_o, SRAM_read_data_i;
  logic [1:0]  owner_o;
  logic        busy_o, SRAM_we_n_o;
  logic [17:0] SRAM_address_o;

  int n_chk  = 0;
  int n_fail = 0;

  sram_arbiter #(.NUM_REQ(3), .READ_LATENCY(3), .MAX_HOLD(8)) dut (
    .Clock_50(Clock_50), .Resetn(Resetn), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .we_n_i(we_n_i), .gnt_o(gnt_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .owner_o(owner_o),
    .busy_o(busy_o), .SRAM_address_o(SRAM_address_o), .SRAM_write_data_o(SRAM_write_data_o),
    .SRAM_we_n_o(SRAM_we_n_o), .SRAM_read_data_i(SRAM_read_data_i)
  );

  always #10 Clock_50 = ~Clock_50;

  function automatic logic [15:0] mem_f(input logic [17:0] a);
    return a[15:0] ^ {a[17:16], 14'h0};
  endfunction

  // Controller model: data for the address issued in cycle t is on SRAM_read_data_i in cycle t+2.
  logic [15:0] p0 = '0;
  logic [15:0] p1 = '0;
  always @(posedge Clock_50) begin
    p0 <= mem_f(SRAM_address_o);
    p1 <= p0;
  end
  assign SRAM_read_data_i = p1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Master k presents address {k, a} and write data wd + k.
  task automatic cyc(input logic rst, input logic [2:0] req, input logic [2:0] we,
                     input logic [15:0] a, input logic [15:0] wd);
    @(posedge Clock_50);
    #1;
    Resetn = ~rst;
    req_i  = req;
    we_n_i = we;
    for (int k = 0; k < 3; k++) begin
      addr_i[18*k +: 18]  = {2'(k), a};
      wdata_i[16*k +: 16] = wd + 16'(k);
    end
    @(negedge Clock_50);
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [15:0] a;
    logic [15:0] wd;
    logic [2:0]  gnt;
    logic        busy;
    logic [1:0]  own;
    logic        wen;
    logic [17:0] addr;
    logic [15:0] wdat;
    logic [2:0]  rv;
    logic [15:0] rd;
  } vec_t;

  vec_t v [20];

  initial begin
    v[0]  = '{1'b0, 3'b001, 3'b111, 16'd0, 16'd0, 3'b000, 1'b0, 2'd0, 1'b1, 18'd0, 16'd0, 3'b000, 16'd0};
    v[1]  = '{1'b0, 3'b001, 3'b111, 16'd0, 16'd0, 3'b001, 1'b1, 2'd0, 1'b1, 18'd0, 16'd0, 3'b000, 16'd0};
    v[2]  = '{1'b0, 3'b001, 3'b111, 16'd1, 16'd0, 3'b001, 1'b1, 2'd0, 1'b1, 18'd1, 16'd0, 3'b000, 16'd0};
    v[3]  = '{1'b0, 3'b001, 3'b111, 16'd2, 16'd0, 3'b001, 1'b1, 2'd0, 1'b1, 18'd2, 16'd0, 3'b000, 16'd0};
    v[4]  = '{1'b0, 3'b001, 3'b111, 16'd3, 16'd0, 3'b001, 1'b1, 2'd0, 1'b1, 18'd3, 16'd0, 3'b001, 16'd0};
    v[5]  = '{1'b0, 3'b000, 3'b111, 16'd3, 16'd0, 3'b001, 1'b1, 2'd0, 1'b1, 18'd3, 16'd0, 3'b001, 16'd1};
    v[6]  = '{1'b0, 3'b000, 3'b111, 16'd3, 16'd0, 3'b000, 1'b0, 2'd0, 1'b1, 18'd3, 16'd0, 3'b001, 16'd2};
    v[7]  = '{1'b0, 3'b000, 3'b111, 16'd3, 16'd0, 3'b000, 1'b0, 2'd0, 1'b1, 18'd3, 16'd0, 3'b001, 16'd3};
    v[8]  = '{1'b1, 3'b000, 3'b111, 16'd0, 16'd0, 3'b000, 1'b0, 2'd0, 1'b1, 18'd0, 16'd0, 3'b000, 16'd0};
    v[9]  = '{1'b0, 3'b111, 3'b111, 16'd10, 16'd0, 3'b000, 1'b0, 2'd0, 1'b1, 18'd0, 16'd0, 3'b000, 16'd0};
    v[10] = '{1'b0, 3'b111, 3'b111, 16'd10, 16'd0, 3'b001, 1'b1, 2'd0, 1'b1, 18'd10, 16'd0, 3'b000, 16'd0};
    v[11] = '{1'b0, 3'b110, 3'b111, 16'd10, 16'd0, 3'b001, 1'b1, 2'd0, 1'b1, 18'd10, 16'd0, 3'b000, 16'd0};
    v[12] = '{1'b0, 3'b110, 3'b111, 16'd10, 16'd0, 3'b000, 1'b0, 2'd0, 1'b1, 18'd10, 16'd0, 3'b000, 16'd0};
    v[13] = '{1'b0, 3'b110, 3'b111, 16'd10, 16'd0, 3'b010, 1'b1, 2'd1, 1'b1, 18'd65546, 16'd0, 3'b001, 16'h000A};
    v[14] = '{1'b0, 3'b100, 3'b111, 16'd10, 16'd0, 3'b010, 1'b1, 2'd1, 1'b1, 18'd65546, 16'd0, 3'b000, 16'd0};
    v[15] = '{1'b0, 3'b100, 3'b111, 16'd10, 16'd0, 3'b000, 1'b0, 2'd0, 1'b1, 18'd65546, 16'd0, 3'b000, 16'd0};
    v[16] = '{1'b0, 3'b100, 3'b011, 16'h3E00, 16'hBEED, 3'b100, 1'b1, 2'd2, 1'b0, 18'd146944, 16'hBEEF, 3'b010, 16'h400A};
    v[17] = '{1'b0, 3'b000, 3'b111, 16'h3E00, 16'hBEED, 3'b100, 1'b1, 2'd2, 1'b1, 18'd146944, 16'd0, 3'b000, 16'd0};
    v[18] = '{1'b0, 3'b000, 3'b111, 16'h3E00, 16'hBEED, 3'b000, 1'b0, 2'd0, 1'b1, 18'd146944, 16'd0, 3'b000, 16'd0};
    v[19] = '{1'b0, 3'b000, 3'b111, 16'h3E00, 16'hBEED, 3'b000, 1'b0, 2'd0, 1'b1, 18'd146944, 16'd0, 3'b000, 16'd0};

    repeat (3) @(posedge Clock_50);

    for (int i = 0; i < 20; i++) begin
      cyc(v[i].rst, v[i].req, v[i].we, v[i].a, v[i].wd);
      chk($sformatf("v%0d gnt", i), 32'(gnt_o), 32'(v[i].gnt));
      chk($sformatf("v%0d busy", i), 32'(busy_o), 32'(v[i].busy));
      chk($sformatf("v%0d we_n", i), 32'(SRAM_we_n_o), 32'(v[i].wen));
      chk($sformatf("v%0d addr", i), 32'(SRAM_address_o), 32'(v[i].addr));
      chk($sformatf("v%0d rvalid", i), 32'(rvalid_o), 32'(v[i].rv));
      if (v[i].busy) chk($sformatf("v%0d owner", i), 32'(owner_o), 32'(v[i].own));
      if (!v[i].wen) chk($sformatf("v%0d wdata", i), 32'(SRAM_write_data_o), 32'(v[i].wdat));
      if (v[i].rv != 3'b000) chk($sformatf("v%0d rdata", i), 32'(rdata_o), 32'(v[i].rd));
    end

    // Read issued by M1 in its last owned cycle returns to M1 after M2 has taken over.
    cyc(1'b1, 3'b000, 3'b111, 16'd0, 16'd0);
    cyc(1'b0, 3'b011, 3'b111, 16'd100, 16'd0);
    cyc(1'b0, 3'b011, 3'b111, 16'd100, 16'd0);
    chk("t3 gnt m1", 32'(gnt_o), 32'(3'b001));
    chk("t3 addr m1", 32'(SRAM_address_o), 32'd100);
    cyc(1'b0, 3'b010, 3'b111, 16'd200, 16'd0);
    chk("t3 gnt tail", 32'(gnt_o), 32'(3'b001));
    cyc(1'b0, 3'b010, 3'b111, 16'd200, 16'd0);
    chk("t3 gnt dead", 32'(gnt_o), 32'(3'b000));
    chk("t3 we_n dead", 32'(SRAM_we_n_o), 32'd1);
    cyc(1'b0, 3'b010, 3'b111, 16'd200, 16'd0);
    chk("t3 gnt m2", 32'(gnt_o), 32'(3'b010));
    chk("t3 addr m2", 32'(SRAM_address_o), 32'd65736);
    chk("t3 rvalid m1", 32'(rvalid_o), 32'(3'b001));
    chk("t3 rdata m1", 32'(rdata_o), 32'h0064);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 3'b000, 3'b111, 16'd200, 16'd0);
      chk($sformatf("t3 rvalid gap%0d", i), 32'(rvalid_o), 32'(3'b000));
    end
    cyc(1'b0, 3'b000, 3'b111, 16'd200, 16'd0);
    chk("t3 rvalid m2", 32'(rvalid_o), 32'(3'b010));
    chk("t3 rdata m2", 32'(rdata_o), 32'h40C8);

    // Forced release after 8 issues while M2 waits.
    cyc(1'b1, 3'b000, 3'b111, 16'd0, 16'd0);
    cyc(1'b0, 3'b001, 3'b111, 16'd0, 16'd0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, (i == 1) ? 3'b001 : 3'b011, 3'b111, 16'(i), 16'd0);
      chk($sformatf("t4 gnt issue%0d", i), 32'(gnt_o), 32'(3'b001));
      chk($sformatf("t4 addr issue%0d", i), 32'(SRAM_address_o), 32'(i));
    end
    cyc(1'b0, 3'b011, 3'b111, 16'd9, 16'd0);
    chk("t4 gnt dead", 32'(gnt_o), 32'(3'b000));
    chk("t4 we_n dead", 32'(SRAM_we_n_o), 32'd1);
    chk("t4 addr hold", 32'(SRAM_address_o), 32'd8);
    cyc(1'b0, 3'b011, 3'b111, 16'd20, 16'd0);
    chk("t4 gnt m2", 32'(gnt_o), 32'(3'b010));
    chk("t4 owner m2", 32'(owner_o), 32'd1);
    chk("t4 addr m2", 32'(SRAM_address_o), 32'd65556);
    chk("t4 rvalid 7", 32'(rvalid_o), 32'(3'b001));
    chk("t4 rdata 7", 32'(rdata_o), 32'd7);
    cyc(1'b0, 3'b011, 3'b111, 16'd20, 16'd0);
    chk("t4 rdata 8", 32'(rdata_o), 32'd8);
    cyc(1'b0, 3'b011, 3'b111, 16'd20, 16'd0);
    chk("t4 rvalid unissued", 32'(rvalid_o), 32'(3'b000));
    cyc(1'b0, 3'b000, 3'b111, 16'd20, 16'd0);
    chk("t4 rvalid m2", 32'(rvalid_o), 32'(3'b010));
    chk("t4 rdata m2", 32'(rdata_o), 32'h4014);
    cyc(1'b0, 3'b000, 3'b111, 16'd20, 16'd0);
    cyc(1'b0, 3'b000, 3'b111, 16'd20, 16'd0);

    // Reset with two reads in flight.
    cyc(1'b0, 3'b001, 3'b111, 16'd5, 16'h1234);
    cyc(1'b0, 3'b001, 3'b111, 16'd5, 16'h1234);
    chk("t6 gnt before", 32'(gnt_o), 32'(3'b001));
    cyc(1'b0, 3'b001, 3'b111, 16'd6, 16'h1234);
    cyc(1'b1, 3'b000, 3'b111, 16'd0, 16'd0);
    chk("t6 rst gnt", 32'(gnt_o), 32'(3'b000));
    chk("t6 rst busy", 32'(busy_o), 32'd0);
    chk("t6 rst owner", 32'(owner_o), 32'd0);
    chk("t6 rst rvalid", 32'(rvalid_o), 32'(3'b000));
    chk("t6 rst rdata", 32'(rdata_o), 32'd0);
    chk("t6 rst we_n", 32'(SRAM_we_n_o), 32'd1);
    chk("t6 rst addr", 32'(SRAM_address_o), 32'd0);
    chk("t6 rst wdata", 32'(SRAM_write_data_o), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 3'b000, 3'b111, 16'd0, 16'd0);
      chk($sformatf("t6 rvalid after%0d", i), 32'(rvalid_o), 32'(3'b000));
      chk($sformatf("t6 busy after%0d", i), 32'(busy_o), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
